// File: rtl/aurora_frame_gen.sv
// aurora_frame_gen: numbered AXI4-Stream test frames with tready backpressure, channel_up gating and link counters
module aurora_frame_gen #(
    parameter logic [15:0] HEADER   = 16'hCAFE,
    parameter int          IDLE_GAP = 4,
    parameter int          LEN_W    = 8
) (
    input  logic             io_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             channel_up,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [0:3]       last_keep,
    output logic [0:31]      tx_data,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [0:3]       tx_tkeep,
    output logic             tx_tlast,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [15:0]      stall_count,
    output logic [15:0]      abort_count
);
    localparam int GW = IDLE_GAP > 1 ? $clog2(IDLE_GAP + 1) : 1;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] len, widx;
    logic [0:3] keep_l;
    logic [15:0] seq;
    logic [GW-1:0] gcnt;
    logic fire, last_w, start, done_w;
    assign last_w = widx == len - LEN_W'(1);
    // channel loss takes priority over a coincident handshake
    assign fire   = tx_tvalid & tx_tready & channel_up;
    assign start  = state == IDLE & enable & channel_up;
    assign done_w = fire & state == PAYLOAD & last_w;
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? HDR : IDLE;
            HDR:     state_nx = !channel_up ? IDLE : tx_tready ? PAYLOAD : HDR;
            PAYLOAD: state_nx = !channel_up ? IDLE : done_w ? (IDLE_GAP == 0 ? IDLE : GAP) : PAYLOAD;
            GAP:     state_nx = gcnt == GW'(1) ? IDLE : GAP;
        endcase
    end
    always_comb begin
        tx_tvalid = state == HDR || state == PAYLOAD;
        tx_data   = state == HDR ? {HEADER, seq} : state == PAYLOAD ? {seq, 16'(widx)} : 32'h0;
        tx_tlast  = state == PAYLOAD && last_w;
        tx_tkeep  = tx_tlast ? keep_l : tx_tvalid ? 4'hF : 4'h0;
        busy      = state != IDLE;
    end
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            len         <= '0;
            widx        <= '0;
            keep_l      <= '0;
            seq         <= '0;
            gcnt        <= '0;
            frame_count <= '0;
            stall_count <= '0;
            abort_count <= '0;
        end else begin
            if (start) begin
                len    <= frame_len < LEN_W'(2) ? LEN_W'(2) : frame_len;
                keep_l <= last_keep inside {4'b1000, 4'b1100, 4'b1110, 4'b1111} ? last_keep : 4'hF;
                widx   <= '0;
            end else if (fire && !last_w) begin
                widx <= widx + LEN_W'(1);
            end
            if (done_w) begin
                seq         <= seq + 16'd1;
                frame_count <= frame_count + 16'd1;
            end
            if (tx_tvalid && !channel_up) abort_count <= abort_count + 16'd1;
            if (tx_tvalid && !tx_tready && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            gcnt <= state == PAYLOAD ? GW'(IDLE_GAP) : state == GAP ? gcnt - GW'(1) : gcnt;
        end
    end
endmodule

// File: tb/tb_aurora_frame_gen.sv
// tb_aurora_frame_gen: directed frames checked by a handshake-driven scoreboard
module tb_aurora_frame_gen;
    logic io_clk = 0, reset_n = 1, enable = 0, en0 = 0, channel_up = 0, tx_tready = 0;
    logic [7:0] frame_len = 8'd4;
    logic [0:3] last_keep = 4'hF;
    logic [0:31] tx_data, tx_data0;
    logic [0:3] tx_tkeep, tx_tkeep0;
    logic tx_tvalid, tx_tlast, busy, tx_tvalid0, tx_tlast0, busy0;
    logic [15:0] frame_count, stall_count, abort_count, fc0, sc0, ac0;
    logic [36:0] exp_q[$];
    logic [36:0] prev_w;
    int total = 0, bad = 0, cyc = 0, last_t = -1, done = 0;
    bit gap_on = 0, prev_stall = 0, prev_valid = 0;

    aurora_frame_gen dut (
        .io_clk(io_clk), .reset_n(reset_n), .enable(enable), .channel_up(channel_up),
        .frame_len(frame_len), .last_keep(last_keep), .tx_data(tx_data), .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .busy(busy),
        .frame_count(frame_count), .stall_count(stall_count), .abort_count(abort_count)
    );
    aurora_frame_gen #(.IDLE_GAP(0)) dut0 (
        .io_clk(io_clk), .reset_n(reset_n), .enable(en0), .channel_up(channel_up),
        .frame_len(frame_len), .last_keep(last_keep), .tx_data(tx_data0), .tx_tvalid(tx_tvalid0),
        .tx_tready(tx_tready), .tx_tkeep(tx_tkeep0), .tx_tlast(tx_tlast0), .busy(busy0),
        .frame_count(fc0), .stall_count(sc0), .abort_count(ac0)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: outputs are stable at the falling edge, so a handshake seen here completes at the next rise
    always @(negedge io_clk) begin
        if (!reset_n) begin
            prev_stall = 0;
            prev_valid = 0;
        end else begin
            cyc++;
            if (prev_stall) check("hold", {tx_tvalid, tx_data, tx_tkeep, tx_tlast}, {1'b1, prev_w});
            if (tx_tvalid && !prev_valid && gap_on && last_t >= 0) check("gap", 40'(cyc - last_t), 40'd6);
            if (tx_tvalid && tx_tready && channel_up) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected: got %h expected none", tx_data);
                end else begin
                    check("word", {tx_data, tx_tkeep, tx_tlast}, exp_q.pop_front());
                end
                if (tx_tlast) begin
                    last_t = cyc;
                    done++;
                end
            end
            prev_stall = tx_tvalid && !tx_tready && channel_up;
            prev_w = {tx_data, tx_tkeep, tx_tlast};
            prev_valid = tx_tvalid;
        end
    end

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({d, k, l});
    endtask

    task automatic push_frame(input logic [15:0] s, input int flen, input logic [0:3] k);
        int n;
        logic [0:3] kk;
        n = flen < 2 ? 2 : flen;
        kk = (k == 4'b1000 || k == 4'b1100 || k == 4'b1110 || k == 4'b1111) ? k : 4'hF;
        push({16'hCAFE, s}, 4'hF, 1'b0);
        for (int w = 1; w < n; w++) push({s, 16'(w)}, w == n - 1 ? kk : 4'hF, w == n - 1);
    endtask

    task automatic pulse(input logic [7:0] flen, input logic [0:3] k);
        frame_len = flen;
        last_keep = k;
        enable = 1;
        step();
        enable = 0;
        frame_len = 8'd9;
        last_keep = 4'b0101;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done < target && n < 200) begin
            step();
            n++;
        end
        check("frame_done", 40'(done), 40'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check("idle", {39'd0, busy}, 40'd0);
    endtask

    task automatic wait_data(input logic [31:0] w);
        int n = 0;
        while (tx_data !== w && n < 50) begin
            step();
            n++;
        end
        check("reach", {8'd0, tx_data}, {8'd0, w});
    endtask

    initial begin
        #1 reset_n = 0;
        #1 check("reset_out", {tx_tvalid, tx_data, tx_tkeep, tx_tlast, busy}, 40'd0);
        check("reset_cnt", {frame_count, stall_count, 8'd0}, 40'd0);
        repeat (3) step();
        reset_n = 1;
        step();
        check("post_reset", {tx_tvalid, busy, abort_count}, 40'd0);

        channel_up = 1;
        tx_tready = 1;
        frame_len = 8'd4;
        last_keep = 4'hF;
        push(32'hCAFE0000, 4'hF, 1'b0);
        push(32'h00000001, 4'hF, 1'b0);
        push(32'h00000002, 4'hF, 1'b0);
        push(32'h00000003, 4'hF, 1'b1);
        push_frame(16'd1, 4, 4'hF);
        gap_on = 1;
        enable = 1;
        wait_done(1);
        check("fc1", 40'(frame_count), 40'd1);
        for (int n = 0; n < 20 && !tx_tvalid; n++) step();
        enable = 0;
        wait_done(2);
        wait_idle();
        repeat (3) step();
        check("stopped", {tx_tvalid, busy, 22'd0, frame_count}, 40'd2);
        gap_on = 0;

        push_frame(16'd2, 4, 4'hF);
        pulse(8'd4, 4'hF);
        wait_data(32'h00020002);
        tx_tready = 0;
        repeat (3) step();
        tx_tready = 1;
        wait_done(3);
        check("stall", 40'(stall_count), 40'd3);
        wait_idle();

        push(32'hCAFE0003, 4'hF, 1'b0);
        push(32'h00030001, 4'hF, 1'b1);
        pulse(8'd1, 4'b1010);
        wait_done(4);
        wait_idle();
        push(32'hCAFE0004, 4'hF, 1'b0);
        push(32'h00040001, 4'b1100, 1'b1);
        pulse(8'd2, 4'b1100);
        wait_done(5);
        wait_idle();

        push(32'hCAFE0005, 4'hF, 1'b0);
        push(32'h00050001, 4'hF, 1'b0);
        pulse(8'd4, 4'hF);
        wait_data(32'h00050002);
        channel_up = 0;
        step();
        check("abort", {tx_tvalid, busy, 6'd0, abort_count, frame_count}, {8'd0, 16'd1, 16'd5});
        step();
        channel_up = 1;
        check("abort_q", 40'(exp_q.size()), 40'd0);
        push_frame(16'd5, 4, 4'hF);
        pulse(8'd4, 4'hF);
        wait_done(6);
        wait_idle();

        frame_len = 8'd3;
        last_keep = 4'hF;
        en0 = 1;
        for (int n = 0; n < 30 && !(tx_tvalid0 && tx_tlast0); n++) step();
        check("g0_last", {tx_tvalid0, tx_tlast0, 6'd0, tx_data0}, {8'hC0, 32'h00000002});
        step();
        check("g0_gap", {tx_tvalid0, 7'd0, 16'd0, fc0}, 40'd1);
        step();
        check("g0_hdr", {tx_tvalid0, 7'd0, tx_data0}, {8'h80, 32'hCAFE0001});
        en0 = 0;

        push(32'hCAFE0006, 4'hF, 1'b0);
        pulse(8'd4, 4'hF);
        wait_data(32'h00060001);
        #2 reset_n = 0;
        #1 check("async_out", {tx_tvalid, tx_data, tx_tkeep, tx_tlast, busy}, 40'd0);
        check("async_cnt", {frame_count, stall_count, abort_count[7:0]}, 40'd0);
        step();
        step();
        reset_n = 1;
        check("async_q", 40'(exp_q.size()), 40'd0);
        push(32'hCAFE0000, 4'hF, 1'b0);
        push(32'h00000001, 4'hF, 1'b0);
        push(32'h00000002, 4'hF, 1'b0);
        push(32'h00000003, 4'hF, 1'b1);
        pulse(8'd4, 4'hF);
        wait_done(7);
        wait_idle();
        check("fc_after", 40'(frame_count), 40'd1);
        check("final_q", 40'(exp_q.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
